bra_predictor: RTL and testbench
================================

Name: bra_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined RV32I core. It generalises the fixed 16-entry, 2-bit, PC-indexed history table into a configurable block:
- table depth and counter width are parameters;
- mode is bimodal or gshare, with a speculative global history register (GHR) and checkpoint/restore;
- saturating performance counters are included.

Fetch stage queries it combinationally. Decode stage returns the resolved outcome one or more cycles later.

Parameters:
ENTRIES, 16, pattern table depth; power of two, >= 4; IDX_W = log2(ENTRIES)
CNT_W, 2, saturating counter width, >= 1
GHR_W, 4, global history length, 1..IDX_W
MODE, 0, 0 = bimodal (index = PC only), 1 = gshare (PC xor GHR)
PERF_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
f_valid  in  1  fetch slot holds a branch (opcode == OP_BRA) and fetch is not stalled
f_pc  in  32  PC of fetched instruction
p_taken  out  1  prediction: MSB of selected counter
p_idx  out  IDX_W  table index used; pipelined alongside the branch
p_ghr  out  GHR_W  GHR value before this prediction's shift (checkpoint)
r_valid  in  1  decode resolves a branch this cycle, not stalled
r_idx  in  IDX_W  p_idx carried with that branch
r_ghr  in  GHR_W  p_ghr carried with that branch
r_taken  in  1  actual outcome
r_mispredict  in  1  actual outcome differs from p_taken carried with the branch
perf_pred  out  PERF_W  resolved branch count
perf_miss  out  PERF_W  mispredict count

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- On rst high:
  - every counter = weakly taken {1'b1, (CNT_W-1)'b0};
  - GHR = 0; perf_pred = perf_miss = 0.
  - Outputs therefore reset to: p_taken = 1, p_ghr = 0, p_idx = f_pc[IDX_W+1:2].
  - Reset asserted mid-operation discards all pending state immediately.
- Index calculation:
  - pcidx = f_pc[IDX_W+1:2].
  - MODE 0: p_idx = pcidx.
  - MODE 1: p_idx = pcidx ^ {(IDX_W-GHR_W)'b0, GHR}.
- Prediction is purely combinational, zero latency: p_taken = table[p_idx][CNT_W-1]. Valid regardless of f_valid; the consumer qualifies it.
- Table update at the clock edge when r_valid:
  - r_taken: increment table[r_idx] unless at all-ones.
  - !r_taken: decrement unless at zero.
  - No wrap-around.
- GHR update at the clock edge, in priority order:
  1. r_valid & r_mispredict: GHR <= {r_ghr[GHR_W-2:0], r_taken}. Restores from checkpoint and discards the wrong-path shift. For GHR_W == 1, GHR <= r_taken.
  2. else f_valid: GHR <= {GHR[GHR_W-2:0], p_taken} (speculative).
  3. else hold.
- The GHR is maintained in both modes; p_ghr is exported in MODE 0 too.
- Simultaneous f_valid and r_valid on the same index: the prediction reads the pre-update value (read-before-write); the update lands at the edge.
- Simultaneous f_valid with a mispredict: the fetched instruction is wrong-path and is flushed externally; the restore wins.
- Perf counters:
  - on r_valid, perf_pred += 1; on r_valid & r_mispredict, perf_miss += 1;
  - both saturate at all-ones and do not wrap.
- r_mispredict without r_valid is ignored.
- The external PC mux and the pcBranchMissed register stay in the core; this block holds no PC state.

Decomposition:
- Shared package def.h gains:
  - OP_BRA (existing);
  - BP_MODE_BIMODAL = 0, BP_MODE_GSHARE = 1;
  - macro for the weakly-taken reset value.
- One natural sub-module: bp_sat_counter (parametrised CNT_W saturating up/down next-value logic). It is reused for the table entries and, with the up-only path, the perf counters.
- The table itself remains inline as a register array; async reset requires flops, not RAM.

Test Plan:
- Reset: rst=1 for 2 cycles, f_pc=0x40 -> p_taken=1, p_idx=0x0 (ENTRIES=16), p_ghr=0, perf_pred=0, perf_miss=0.
- Saturation: MODE 0, r_valid with r_idx=3, r_taken=1 for 4 cycles -> table[3]=2'b11 and stays; then r_taken=0 for 5 cycles -> 2'b00 and stays; f_pc=0x0C gives p_taken=0.
- Gshare index: MODE 1, three f_valid cycles with p_taken=1 -> GHR=4'b0111; f_pc=0x20 -> p_idx = 0x8 ^ 0x7 = 0xF, p_ghr=4'b0111.
- Mispredict restore: GHR=4'b0101, f_valid and r_valid same cycle with r_mispredict=1, r_ghr=4'b0010, r_taken=1 -> next GHR=4'b0101 restored as 4'b0101 ({010,1}); speculative shift discarded; perf_miss increments by 1.
- Same-index collision: table[5]=2'b01, f_pc=0x14 with r_valid, r_idx=5, r_taken=1 -> p_taken=0 that cycle; p_taken=1 next cycle.
- Perf saturation: PERF_W=4, 20 resolved mispredicts -> perf_pred=perf_miss=4'hF; async rst pulse mid-sequence -> both 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/bra_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor.
package bra_predictor_pkg;

    // Branch opcode used by fetch to qualify f_valid.
    localparam logic [6:0] OP_BRA = 7'b1100011;

    // Predictor indexing modes.
    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Weakly-taken reset value for a w-bit counter: MSB set, rest clear.
    function automatic logic [31:0] bp_weak_taken(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/bra_predictor_sat_counter.sv
// Saturating up/down next-value logic; holds at all-ones going up and at zero going down.
module bp_sat_counter
    import bra_predictor_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] nxt
);

    // Step toward the requested direction unless already at that end.
    always_comb begin
        nxt = cnt;
        if (en) begin
            if (up && (cnt != '1))
                nxt = cnt + 1'b1;
            else if (!up && (cnt != '0))
                nxt = cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bra_predictor.sv
// Dynamic branch predictor: bimodal or gshare pattern table, speculative GHR
// with checkpoint restore, and saturating resolved/mispredict counters.
module bra_predictor
    import bra_predictor_pkg::*;
#(
    parameter  int ENTRIES = 16,
    parameter  int CNT_W   = 2,
    parameter  int GHR_W   = 4,
    parameter  int MODE    = BP_MODE_BIMODAL,
    parameter  int PERF_W  = 32,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [31:0]       f_pc,
    output logic              p_taken,
    output logic [IDX_W-1:0]  p_idx,
    output logic [GHR_W-1:0]  p_ghr,
    input  logic              r_valid,
    input  logic [IDX_W-1:0]  r_idx,
    input  logic [GHR_W-1:0]  r_ghr,
    input  logic              r_taken,
    input  logic              r_mispredict,
    output logic [PERF_W-1:0] perf_pred,
    output logic [PERF_W-1:0] perf_miss
);

    localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(bp_weak_taken(CNT_W));

    logic [CNT_W-1:0]  tbl_q [ENTRIES];
    logic [CNT_W-1:0]  tbl_d [ENTRIES];
    logic [CNT_W-1:0]  upd_cnt;
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [PERF_W-1:0] perf_pred_q, perf_pred_d;
    logic [PERF_W-1:0] perf_miss_q, perf_miss_d;
    logic [IDX_W-1:0]  pcidx;
    logic              unused_pc;

    // Only the word-index bits of the PC select an entry.
    assign pcidx     = f_pc[IDX_W+1:2];
    assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

    // Zero-latency lookup; reads the table before any same-cycle update.
    assign p_idx   = (MODE == BP_MODE_GSHARE) ? (pcidx ^ IDX_W'(ghr_q)) : pcidx;
    assign p_taken = tbl_q[p_idx][CNT_W-1];
    assign p_ghr   = ghr_q;

    assign perf_pred = perf_pred_q;
    assign perf_miss = perf_miss_q;

    bp_sat_counter #(.W(CNT_W)) u_tbl_cnt (
        .cnt (tbl_q[r_idx]),
        .en  (r_valid),
        .up  (r_taken),
        .nxt (upd_cnt)
    );

    bp_sat_counter #(.W(PERF_W)) u_perf_pred (
        .cnt (perf_pred_q),
        .en  (r_valid),
        .up  (1'b1),
        .nxt (perf_pred_d)
    );

    bp_sat_counter #(.W(PERF_W)) u_perf_miss (
        .cnt (perf_miss_q),
        .en  (r_valid & r_mispredict),
        .up  (1'b1),
        .nxt (perf_miss_d)
    );

    // Train only the resolved entry.
    always_comb begin
        tbl_d = tbl_q;
        if (r_valid)
            tbl_d[r_idx] = upd_cnt;
    end

    // Mispredict restores from the branch's checkpoint and overrides any
    // wrong-path speculative shift; otherwise fetch shifts in its prediction.
    // Truncating {hist, bit} to GHR_W keeps the newest GHR_W bits and also
    // covers a one-bit history.
    always_comb begin
        ghr_d = ghr_q;
        if (r_valid && r_mispredict)
            ghr_d = GHR_W'({r_ghr, r_taken});
        else if (f_valid)
            ghr_d = GHR_W'({ghr_q, p_taken});
    end

    // Pattern table flops; reset to weakly taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl_q[i] <= WEAK_TAKEN;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // History and performance counter flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q       <= '0;
            perf_pred_q <= '0;
            perf_miss_q <= '0;
        end else begin
            ghr_q       <= ghr_d;
            perf_pred_q <= perf_pred_d;
            perf_miss_q <= perf_miss_d;
        end
    end

endmodule

// File: tb/tb_bra_predictor.sv
// Bench: a bimodal DUT (PERF_W=32) and a gshare DUT (PERF_W=4) share stimulus;
// a behavioural model is compared every negedge, plus hand-computed literals.
module tb_bra_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic        r_valid = 1'b0, r_taken = 1'b0, r_mispredict = 1'b0;
    logic [3:0]  r_idx = '0, r_ghr = '0;

    logic        p_taken0, p_taken1;
    logic [3:0]  p_idx0, p_idx1, p_ghr0, p_ghr1;
    logic [31:0] perf_pred0, perf_miss0;
    logic [3:0]  perf_pred1, perf_miss1;

    bra_predictor #(.ENTRIES(16), .CNT_W(2), .GHR_W(4), .MODE(0), .PERF_W(32)) u_bim (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
        .p_taken(p_taken0), .p_idx(p_idx0), .p_ghr(p_ghr0),
        .r_valid(r_valid), .r_idx(r_idx), .r_ghr(r_ghr), .r_taken(r_taken),
        .r_mispredict(r_mispredict), .perf_pred(perf_pred0), .perf_miss(perf_miss0)
    );

    bra_predictor #(.ENTRIES(16), .CNT_W(2), .GHR_W(4), .MODE(1), .PERF_W(4)) u_gsh (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
        .p_taken(p_taken1), .p_idx(p_idx1), .p_ghr(p_ghr1),
        .r_valid(r_valid), .r_idx(r_idx), .r_ghr(r_ghr), .r_taken(r_taken),
        .r_mispredict(r_mispredict), .perf_pred(perf_pred1), .perf_miss(perf_miss1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state, index 0 = bimodal DUT, 1 = gshare DUT. Counters are 0..3.
    int     m_tbl [2][16];
    int     m_ghr [2];
    longint m_pp  [2];
    longint m_pm  [2];
    longint m_cap [2] = '{64'hFFFF_FFFF, 15};

    function automatic int m_idx(input int d);
        int pci;
        pci = int'(f_pc[5:2]);
        return (d == 1) ? (pci ^ m_ghr[d]) : pci;
    endfunction

    function automatic int m_taken(input int d);
        return (m_tbl[d][m_idx(d)] >= 2) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge for both predictors.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 16; i++) m_tbl[d][i] = 2;
                m_ghr[d] = 0; m_pp[d] = 0; m_pm[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int pt;
                int ri;
                pt = m_taken(d);
                ri = int'(r_idx);
                if (r_valid) begin
                    if (r_taken) m_tbl[d][ri] = (m_tbl[d][ri] == 3) ? 3 : m_tbl[d][ri] + 1;
                    else         m_tbl[d][ri] = (m_tbl[d][ri] == 0) ? 0 : m_tbl[d][ri] - 1;
                    if (m_pp[d] < m_cap[d]) m_pp[d] = m_pp[d] + 1;
                    if (r_mispredict && m_pm[d] < m_cap[d]) m_pm[d] = m_pm[d] + 1;
                end
                if (r_valid && r_mispredict)
                    m_ghr[d] = ((int'(r_ghr) << 1) | int'(r_taken)) & 15;
                else if (f_valid)
                    m_ghr[d] = ((m_ghr[d] << 1) | pt) & 15;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bim_taken", 64'(p_taken0),   64'(m_taken(0)));
            chk("bim_idx",   64'(p_idx0),     64'(m_idx(0)));
            chk("bim_ghr",   64'(p_ghr0),     64'(m_ghr[0]));
            chk("bim_pred",  64'(perf_pred0), m_pp[0]);
            chk("bim_miss",  64'(perf_miss0), m_pm[0]);
            chk("gsh_taken", 64'(p_taken1),   64'(m_taken(1)));
            chk("gsh_idx",   64'(p_idx1),     64'(m_idx(1)));
            chk("gsh_ghr",   64'(p_ghr1),     64'(m_ghr[1]));
            chk("gsh_pred",  64'(perf_pred1), m_pp[1]);
            chk("gsh_miss",  64'(perf_miss1), m_pm[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1; f_pc = 32'h40;
        #1 chk_en = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_taken", 64'(p_taken0), 1);
        chk("rst_idx",   64'(p_idx0), 0);
        chk("rst_ghr",   64'(p_ghr1), 0);
        chk("rst_pred",  64'(perf_pred0), 0);
        chk("rst_miss",  64'(perf_miss1), 0);
        rst = 1'b0;

        // Saturation on entry 3: up four times, then down five times
        f_pc = 32'h0C; r_valid = 1'b1; r_idx = 4'd3; r_taken = 1'b1;
        repeat (4) step();
        chk("sat_hi", 64'(p_taken0), 1);
        r_taken = 1'b0;
        repeat (5) step();
        r_valid = 1'b0;
        #1;
        chk("sat_lo", 64'(p_taken0), 0);
        chk("sat_pred_cnt", 64'(perf_pred0), 9);

        // Gshare index: three taken predictions fill GHR with 0111
        f_pc = 32'h20; f_valid = 1'b1;
        repeat (3) step();
        f_valid = 1'b0;
        #1;
        chk("gsh_idx_xor", 64'(p_idx1), 64'hF);
        chk("gsh_ghr_chk", 64'(p_ghr1), 64'h7);
        chk("bim_idx_pc",  64'(p_idx0), 64'h8);

        // Mispredict restore: reach GHR=0101, then restore wins over fetch shift
        r_valid = 1'b1; r_mispredict = 1'b1; r_ghr = 4'b0010; r_taken = 1'b1; r_idx = 4'd12;
        step();
        chk("pre_restore_ghr", 64'(p_ghr1), 64'h5);
        f_valid = 1'b1;
        step();
        f_valid = 1'b0; r_valid = 1'b0; r_mispredict = 1'b0;
        #1;
        chk("restore_ghr", 64'(p_ghr1), 64'h5);
        chk("restore_miss", 64'(perf_miss0), 2);

        // Same-index collision: table[5] = 01, read-before-write
        r_valid = 1'b1; r_idx = 4'd5; r_taken = 1'b0;
        step();
        f_pc = 32'h14; f_valid = 1'b1; r_taken = 1'b1;
        #1;
        chk("coll_pre", 64'(p_taken0), 0);
        step();
        f_valid = 1'b0; r_valid = 1'b0;
        #1;
        chk("coll_post", 64'(p_taken0), 1);

        // Perf saturation then asynchronous reset mid-cycle
        r_valid = 1'b1; r_mispredict = 1'b1; r_taken = 1'b0; r_idx = 4'd1; r_ghr = 4'd0;
        repeat (20) step();
        chk("perf_sat_pred", 64'(perf_pred1), 64'hF);
        chk("perf_sat_miss", 64'(perf_miss1), 64'hF);
        chk("perf_wide_miss", 64'(perf_miss0), 22);
        r_valid = 1'b0; r_mispredict = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pred", 64'(perf_pred1), 0);
        chk("arst_miss", 64'(perf_miss1), 0);
        chk("arst_wide", 64'(perf_pred0), 0);
        chk("arst_ghr",  64'(p_ghr1), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Mixed traffic sweep checked by the model
        for (int i = 0; i < 32; i++) begin
            f_pc = 32'(i * 4);
            f_valid = i[0];
            r_valid = i[1] | i[4];
            r_idx = 4'(i * 3);
            r_taken = i[2];
            r_mispredict = i[3];
            r_ghr = 4'(~i);
            step();
        end
        f_valid = 1'b0; r_valid = 1'b0; r_mispredict = 1'b0;
        step();
        @(negedge clk);
        #1 chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
